// File: rtl/var_delay_line.sv
// var_delay_line: WIDTH-bit, DEPTH-stage stallable delay line with per-word valid,
// flush, runtime output tap and registered occupancy. Optional: VAR_DELAY_LINE_ZERO_INVALID_EN.
module var_delay_line #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              TW        = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int              FW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TW-1:0]    tap,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [FW-1:0]    fill
);

  localparam logic [TW:0]   DEPTH_W  = (TW + 1)'(DEPTH);
  localparam logic [TW-1:0] LAST_TAP = TW'(DEPTH - 1);

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] vld_nxt;
  logic [TW-1:0]    ts;

  function automatic logic [FW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [FW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + FW'(v[i]);
    return c;
  endfunction

  // Out-of-range taps select the last stage
  function automatic logic [TW-1:0] clamp_tap(input logic [TW-1:0] t);
    if ({1'b0, t} < DEPTH_W) return t;
    return LAST_TAP;
  endfunction

  always_comb begin
    vld_nxt = vld_p;
    if (rst || flush)
      vld_nxt = '0;
    else if (en)
      vld_nxt = {vld_p[DEPTH-2:0], d_valid};
  end

  // Stage boundary: shift register, valid vector and occupancy all advance together
  always_ff @(posedge clk) begin
    vld_p <= vld_nxt;
    fill  <= popcount(vld_nxt);
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_VAL;
    end else if (en) begin
      data_p[0] <= d;
      for (int i = 1; i < DEPTH; i++) data_p[i] <= data_p[i-1];
    end
  end

  assign ts      = clamp_tap(tap);
  assign q_valid = vld_p[ts];

`ifdef VAR_DELAY_LINE_ZERO_INVALID_EN
  assign q = vld_p[ts] ? data_p[ts] : RESET_VAL;
`else
  assign q = data_p[ts];
`endif

endmodule
